// File: rtl/fetch_stage_pkg.sv
// Core-wide constants shared by fetch, the immediate generator and the control decoder.
package fetch_stage_pkg;

  localparam logic [31:0] CORE_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] CORE_RESET_PC = 32'h4000_0000;  // BIOS base

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a synchronous-read IMEM,
// holds the current instruction across stalls and kills the wrong path on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CORE_RESET_PC,
  parameter logic [31:0] NOP_INST = CORE_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_f, pc_nx;
  logic [31:0] hold_inst, hold_nx;
  logic [31:0] pc_inc;
  logic [31:0] redir_pc;

  assign pc_inc   = pc_f + 32'd4;
  assign redir_pc = redirect_pc & ~32'h3;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc_f;
    hold_nx    = hold_inst;
    imem_addr  = pc_f;
    imem_en    = 1'b0;
    inst_out   = NOP_INST;
    pc_out     = pc_f;
    inst_valid = 1'b0;
    if (rst) begin
      imem_addr = RESET_PC;
      pc_out    = RESET_PC;
    end else begin
      case (state)
        BOOT: begin
          imem_en  = 1'b1;
          state_nx = RUN;
          if (redirect_valid) begin
            imem_addr = redir_pc;
            pc_nx     = redir_pc;
          end
        end
        RUN, HOLD: begin
          inst_out   = (state == HOLD) ? hold_inst : imem_rdata;
          inst_valid = 1'b1;
          // Redirect outranks stall: the presented instruction is on the wrong path.
          if (redirect_valid) begin
            inst_out   = NOP_INST;
            inst_valid = 1'b0;
            imem_addr  = redir_pc;
            imem_en    = 1'b1;
            pc_nx      = redir_pc;
            state_nx   = RUN;
          end else if (stall) begin
            imem_en  = 1'b0;
            imem_addr = pc_f;
            if (state == RUN) hold_nx = imem_rdata;
            state_nx = HOLD;
          end else begin
            imem_addr = pc_inc;
            imem_en   = 1'b1;
            pc_nx     = pc_inc;
            state_nx  = RUN;
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc_f      <= RESET_PC;
      hold_inst <= NOP_INST;
    end else begin
      state     <= state_nx;
      pc_f      <= pc_nx;
      hold_inst <= hold_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver pushes per-cycle expectations, a monitor
// pops and compares them on the falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h4000_0000;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
  );

  // Instruction image: two fixed words at the BIOS base, elsewhere {addr[15:0],16'h0093}.
  function automatic logic [31:0] img(input logic [31:0] a);
    if (a == 32'h4000_0000) return 32'h0050_0093;
    if (a == 32'h4000_0004) return 32'h00A0_0113;
    return {a[15:0], 16'h0093};
  endfunction

  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= img(imem_addr);
  end

  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                     input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] a, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    x.valid = v; x.inst = i; x.pc = p; x.addr = a; x.en = e;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", step, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, x.valid});
      chk("inst_out",   inst_out,  x.inst);
      chk("pc_out",     pc_out,    x.pc);
      chk("imem_addr",  imem_addr, x.addr);
      chk("imem_en",    {31'd0, imem_en}, {31'd0, x.en});
      step++;
    end
  end

  initial begin
    imem_rdata = 32'h0; rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    //  rst stl rv  rpc            valid inst          pc             addr           en
    cyc(1, 0, 0, 32'h0,          0, NOP,          RPC,           RPC,           0);
    cyc(1, 0, 0, 32'h0,          0, NOP,          RPC,           RPC,           0);
    // Reset release, straight-line fetch
    cyc(0, 0, 0, 32'h0,          0, NOP,          RPC,           32'h4000_0000, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0050_0093, 32'h4000_0000, 32'h4000_0004, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h00A0_0113, 32'h4000_0004, 32'h4000_0008, 1);
    // Three-cycle stall at 0x4000_0008
    cyc(0, 1, 0, 32'h0,          1, 32'h0008_0093, 32'h4000_0008, 32'h4000_0008, 0);
    cyc(0, 1, 0, 32'h0,          1, 32'h0008_0093, 32'h4000_0008, 32'h4000_0008, 0);
    cyc(0, 1, 0, 32'h0,          1, 32'h0008_0093, 32'h4000_0008, 32'h4000_0008, 0);
    cyc(0, 0, 0, 32'h0,          1, 32'h0008_0093, 32'h4000_0008, 32'h4000_000C, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h000C_0093, 32'h4000_000C, 32'h4000_0010, 1);
    // Reset, then redirect in RUN at 0x4000_0004 to a misaligned target
    cyc(1, 0, 0, 32'h0,          0, NOP,          RPC,           RPC,           0);
    cyc(0, 0, 0, 32'h0,          0, NOP,          RPC,           32'h4000_0000, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0050_0093, 32'h4000_0000, 32'h4000_0004, 1);
    cyc(0, 0, 1, 32'h4000_0103,  0, NOP,          32'h4000_0004, 32'h4000_0100, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0100_0093, 32'h4000_0100, 32'h4000_0104, 1);
    // Stall into HOLD, then redirect and stall together
    cyc(0, 1, 0, 32'h0,          1, 32'h0104_0093, 32'h4000_0104, 32'h4000_0104, 0);
    cyc(0, 1, 1, 32'h4000_0200,  0, NOP,          32'h4000_0104, 32'h4000_0200, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0200_0093, 32'h4000_0200, 32'h4000_0204, 1);
    // Reset asserted mid-HOLD
    cyc(0, 1, 0, 32'h0,          1, 32'h0204_0093, 32'h4000_0204, 32'h4000_0204, 0);
    cyc(0, 1, 0, 32'h0,          1, 32'h0204_0093, 32'h4000_0204, 32'h4000_0204, 0);
    cyc(1, 1, 0, 32'h0,          0, NOP,          RPC,           RPC,           0);
    cyc(0, 0, 0, 32'h0,          0, NOP,          RPC,           32'h4000_0000, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0050_0093, 32'h4000_0000, 32'h4000_0004, 1);
    // Redirect to the top of memory: PC wraps to zero
    cyc(0, 0, 1, 32'hFFFF_FFFC,  0, NOP,          32'h4000_0004, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'hFFFC_0093, 32'hFFFF_FFFC, 32'h0000_0000, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0000_0093, 32'h0000_0000, 32'h0000_0004, 1);
    // Redirect taken during BOOT
    cyc(1, 0, 0, 32'h0,          0, NOP,          RPC,           RPC,           0);
    cyc(0, 0, 1, 32'h4000_0013,  0, NOP,          RPC,           32'h4000_0010, 1);
    cyc(0, 0, 0, 32'h0,          1, 32'h0010_0093, 32'h4000_0010, 32'h4000_0014, 1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core. Sits directly upstream of decode: its inst_out drives the immediate generator, register-file read addresses and the control decoder.
- Owns the fetch PC and drives a synchronous-read instruction memory (address in cycle N, data in cycle N+1).
- Supports pipeline stall with a hold buffer, and redirect (branch/jump/flush) with wrong-path kill.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset (BIOS base).
- NOP_INST, 32'h0000_0013, instruction emitted when the output is invalid or killed (addi x0,x0,0).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream cannot accept; hold current instruction
- redirect_valid  in  1  redirect fetch to redirect_pc; kill the current output
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00)
- imem_addr  out  32  instruction memory read address (byte address, combinational)
- imem_en  out  1  instruction memory read enable; memory holds rdata when 0
- imem_rdata  in  32  memory data for the address captured at the previous edge
- inst_out  out  32  instruction presented to decode
- pc_out  out  32  PC of inst_out
- inst_valid  out  1  inst_out is a real, non-killed instruction

Behaviour:
- State registers: pc_f (32, PC whose data is on imem_rdata), state (BOOT/RUN/HOLD), hold_inst (32).
- Reset (rst=1, synchronous, overrides everything, including mid-stall and mid-redirect):
  - Next state: state<=BOOT, pc_f<=RESET_PC, hold_inst<=NOP_INST.
  - Outputs while rst=1: imem_addr=RESET_PC, imem_en=0, inst_out=NOP_INST, inst_valid=0, pc_out=RESET_PC.
- BOOT:
  - Outputs: inst_out=NOP_INST, inst_valid=0, pc_out=pc_f.
  - If redirect_valid: imem_addr=redirect_pc, pc_f<=redirect_pc.
  - Otherwise: imem_addr=pc_f.
  - imem_en=1; next state RUN regardless of stall.
  - First valid instruction appears in the 2nd cycle after rst deasserts.
- RUN:
  - Default outputs: inst_out=imem_rdata, pc_out=pc_f, inst_valid=1.
  - redirect_valid (highest priority):
    - Kill: inst_out=NOP_INST, inst_valid=0.
    - imem_addr={redirect_pc[31:2],2'b00}, imem_en=1, pc_f<=that address.
    - Stay RUN. Target instruction is valid in the next cycle (1 dead cycle).
  - else stall: imem_en=0, imem_addr=pc_f, hold_inst<=imem_rdata; next state HOLD.
  - else: imem_addr=pc_f+4, imem_en=1, pc_f<=pc_f+4.
- HOLD:
  - Default outputs: inst_out=hold_inst, pc_out=pc_f, inst_valid=1.
  - redirect_valid: same as RUN redirect (kill, fetch target); next state RUN. Redirect beats stall.
  - else stall: imem_en=0, imem_addr=pc_f; stay HOLD; hold_inst unchanged.
  - else: imem_addr=pc_f+4, imem_en=1, pc_f<=pc_f+4; next state RUN. Held instruction is consumed this cycle.
- Arithmetic:
  - pc_f+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - pc_f[1:0] is always 00; no misalignment exception in this block.
- Outputs depend on state/regs, imem_rdata, and (combinationally) redirect_valid and stall. There is no combinational path from imem_rdata to imem_addr.
- Throughput: one instruction per cycle with no stall or redirect. Stall of k cycles repeats the same {inst_out, pc_out} for k+1 cycles.

Decomposition:
- Shared core constants package/header holds NOP_INST, RESET_PC default and the opcode constants (7'h03, 13, 17, 23, 37, 63, 67, 6F, 73), shared with the immediate generator and control decoder.
- State encoding localparams (BOOT, RUN, HOLD) stay local to this module.
- No sub-module: the PC incrementer and next-address mux are inline.

Test Plan:
- Reset release, no stall, IMEM[0x4000_0000..]=0x00500093, 0x00A00113: inst_valid=0 for the 1st cycle after rst falls. Cycle 2: inst_out=0x00500093, pc_out=0x4000_0000. Cycle 3: 0x00A00113 at 0x4000_0004.
- stall high 3 cycles while pc_out=0x4000_0008: inst_out/pc_out held 4 cycles, imem_en=0 during stall, then 0x4000_000C follows with no duplicate or skip.
- redirect_valid with redirect_pc=0x4000_0103 in RUN at pc 0x4000_0004: that cycle inst_valid=0, inst_out=0x00000013, imem_addr=0x4000_0100. Next cycle pc_out=0x4000_0100, valid=1.
- redirect_valid and stall both high in HOLD: redirect wins, state to RUN, target valid next cycle, held instruction discarded.
- rst asserted mid-HOLD: next cycle BOOT, inst_valid=0, pc_out=0x4000_0000. Fetch restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC, no stall: pc_out 0xFFFF_FFFC then 0x0000_0000.
